// File: rtl/ready_valid_fork_n.sv
// N-way ready/valid fork (multicast). One upstream token goes to every output
// selected by its mask. EAGER=1 remembers which outputs already took the token,
// so each output can accept on its own. EAGER=0 is a combinational fork that
// only fires when all selected outputs are ready together.
module ready_valid_fork_n #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int EAGER      = 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            s_valid,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic [NUM_PORTS-1:0]            s_mask,
  output logic                            s_ready,
  output logic [NUM_PORTS-1:0]            m_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] m_data,
  input  logic [NUM_PORTS-1:0]            m_ready,
  output logic                            busy
);

  logic [NUM_PORTS-1:0] done_q;
  logic [NUM_PORTS-1:0] done_d;
  logic [NUM_PORTS-1:0] need;
  logic [NUM_PORTS-1:0] ok;
  logic [NUM_PORTS-1:0] fire;
  logic                 others_ok;

  // Every output sees the upstream payload with no latency.
  assign m_data = {NUM_PORTS{s_data}};

  assign busy = |done_q;

  // An output still owes a delivery if it is selected and has not fired yet;
  // upstream is released once every owing output is ready this cycle.
  always_comb begin
    need    = s_mask & ~done_q;
    ok      = ~need | m_ready;
    s_ready = &ok;
  end

  // Per-output valid: eager presents each owing output on its own; lazy only
  // presents an output when all the other selected outputs are ready too.
  always_comb begin
    m_valid   = '0;
    others_ok = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (EAGER != 0) begin
        m_valid[i] = s_valid & need[i];
      end else begin
        others_ok = 1'b1;
        for (int j = 0; j < NUM_PORTS; j++) begin
          if (j != i) begin
            others_ok = others_ok & ok[j];
          end
        end
        m_valid[i] = s_valid & s_mask[i] & others_ok;
      end
    end
  end

  assign fire = m_valid & m_ready;

  // Retiring the token clears the record, including outputs firing this cycle,
  // so a zero-latency delivery never leaves done bits behind.
  always_comb begin
    done_d = done_q;
    if (EAGER == 0) begin
      done_d = '0;
    end else if (s_valid && s_ready) begin
      done_d = '0;
    end else begin
      done_d = done_q | fire;
    end
  end

  // Delivery record register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

`ifndef SYNTHESIS
  // Upstream must hold the token steady while it is partially delivered.
  property p_upstream_stable;
    @(posedge clk) disable iff (!rstn)
      busy |-> ($stable(s_data) && $stable(s_mask));
  endproperty
  a_upstream_stable: assert property (p_upstream_stable);
`endif

endmodule

// File: tb/tb_ready_valid_fork_n.sv
// Bench for ready_valid_fork_n: directed cases on an eager 3-port and a lazy
// 2-port instance, then random eager traffic checked by a scoreboard.
module tb_ready_valid_fork_n;

  logic clk = 1'b0;
  logic rstn;

  logic        e_s_valid;
  logic [7:0]  e_s_data;
  logic [2:0]  e_s_mask;
  logic        e_s_ready;
  logic [2:0]  e_m_valid;
  logic [23:0] e_m_data;
  logic [2:0]  e_m_ready;
  logic        e_busy;

  logic        l_s_valid;
  logic [7:0]  l_s_data;
  logic [1:0]  l_s_mask;
  logic        l_s_ready;
  logic [1:0]  l_m_valid;
  logic [15:0] l_m_data;
  logic [1:0]  l_m_ready;
  logic        l_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit rnd_en    = 1'b0;

  logic [7:0] exp_q [3][$];

  always #5 clk = ~clk;

  ready_valid_fork_n #(.DATA_WIDTH(8), .NUM_PORTS(3), .EAGER(1)) u_e (
    .clk(clk), .rstn(rstn),
    .s_valid(e_s_valid), .s_data(e_s_data), .s_mask(e_s_mask), .s_ready(e_s_ready),
    .m_valid(e_m_valid), .m_data(e_m_data), .m_ready(e_m_ready), .busy(e_busy)
  );

  ready_valid_fork_n #(.DATA_WIDTH(8), .NUM_PORTS(2), .EAGER(0)) u_l (
    .clk(clk), .rstn(rstn),
    .s_valid(l_s_valid), .s_data(l_s_data), .s_mask(l_s_mask), .s_ready(l_s_ready),
    .m_valid(l_m_valid), .m_data(l_m_data), .m_ready(l_m_ready), .busy(l_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: an output may only present the token at the head of
  // its queue; a handshake consumes that entry; a retiring token must leave
  // nothing owed on any selected output.
  always @(negedge clk) begin
    if (rnd_en && rstn) begin
      for (int i = 0; i < 3; i++) begin
        if (e_m_valid[i]) begin
          chk("presented_expected", 32'((exp_q[i].size() != 0) && (exp_q[i][0] == e_s_data)), 32'd1);
          if (e_m_ready[i] && exp_q[i].size() != 0) begin
            chk("deliver_data", 32'(e_m_data[i*8 +: 8]), 32'(exp_q[i][0]));
            void'(exp_q[i].pop_front());
          end
        end
      end
      if (e_s_valid && e_s_ready) begin
        for (int i = 0; i < 3; i++) begin
          if (e_s_mask[i]) begin
            chk("retire_all_delivered",
                32'((exp_q[i].size() != 0) && (exp_q[i][0] == e_s_data)), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  acc;
    logic [2:0] mask;

    rstn = 1'b0;
    e_s_valid = 0; e_s_data = 0; e_s_mask = 0; e_m_ready = 0;
    l_s_valid = 0; l_s_data = 0; l_s_mask = 0; l_m_ready = 0;
    #12;
    chk("rst_busy", 32'(e_busy), 32'd0);
    chk("rst_m_valid", 32'(e_m_valid), 32'd0);
    chk("rst_s_ready", 32'(e_s_ready), 32'd1);
    step();
    rstn = 1'b1;
    step();

    // All outputs ready in the first cycle: zero-latency retire.
    e_s_valid = 1; e_s_data = 8'hA5; e_s_mask = 3'b111; e_m_ready = 3'b111;
    @(negedge clk);
    chk("zl_m_valid", 32'(e_m_valid), 32'h7);
    chk("zl_s_ready", 32'(e_s_ready), 32'd1);
    chk("zl_m_data", 32'(e_m_data), 32'hA5A5A5);
    chk("zl_busy", 32'(e_busy), 32'd0);
    step();
    e_s_valid = 0;
    chk("zl_busy_after", 32'(e_busy), 32'd0);

    // Outputs accept one at a time.
    step();
    e_s_valid = 1; e_s_data = 8'h3C; e_s_mask = 3'b111; e_m_ready = 3'b001;
    @(negedge clk);
    chk("seq_c0_m_valid", 32'(e_m_valid), 32'h7);
    chk("seq_c0_s_ready", 32'(e_s_ready), 32'd0);
    step();
    e_m_ready = 3'b010;
    @(negedge clk);
    chk("seq_c1_m_valid", 32'(e_m_valid), 32'h6);
    chk("seq_c1_busy", 32'(e_busy), 32'd1);
    chk("seq_c1_s_ready", 32'(e_s_ready), 32'd0);
    step();
    e_m_ready = 3'b100;
    @(negedge clk);
    chk("seq_c2_m_valid", 32'(e_m_valid), 32'h4);
    chk("seq_c2_busy", 32'(e_busy), 32'd1);
    chk("seq_c2_s_ready", 32'(e_s_ready), 32'd1);
    step();
    e_s_valid = 0;
    @(negedge clk);
    chk("seq_c3_busy", 32'(e_busy), 32'd0);

    // Unselected output ready does not release the token.
    step();
    e_s_valid = 1; e_s_data = 8'h5A; e_s_mask = 3'b101; e_m_ready = 3'b010;
    @(negedge clk);
    chk("mask_m_valid", 32'(e_m_valid), 32'h5);
    chk("mask_s_ready", 32'(e_s_ready), 32'd0);
    step();
    e_m_ready = 3'b101;
    @(negedge clk);
    chk("mask_s_ready2", 32'(e_s_ready), 32'd1);
    chk("mask_m_valid2", 32'(e_m_valid), 32'h5);
    step();
    e_s_mask = 3'b000; e_m_ready = 3'b000;
    @(negedge clk);
    chk("empty_mask_s_ready", 32'(e_s_ready), 32'd1);
    chk("empty_mask_m_valid", 32'(e_m_valid), 32'd0);
    step();
    e_s_valid = 0;
    @(negedge clk);
    chk("empty_mask_busy", 32'(e_busy), 32'd0);

    // Lazy fork.
    step();
    l_s_valid = 1; l_s_data = 8'h77; l_s_mask = 2'b11; l_m_ready = 2'b01;
    @(negedge clk);
    chk("lazy_m_valid", 32'(l_m_valid), 32'h2);
    chk("lazy_s_ready", 32'(l_s_ready), 32'd0);
    step();
    chk("lazy_busy", 32'(l_busy), 32'd0);
    l_m_ready = 2'b11;
    @(negedge clk);
    chk("lazy_m_valid2", 32'(l_m_valid), 32'h3);
    chk("lazy_s_ready2", 32'(l_s_ready), 32'd1);
    chk("lazy_m_data", 32'(l_m_data), 32'h7777);
    step();
    l_s_valid = 0;

    // Reset in the middle of a partially delivered token.
    step();
    e_s_valid = 1; e_s_data = 8'hC3; e_s_mask = 3'b111; e_m_ready = 3'b001;
    @(negedge clk);
    chk("rstmid_m_valid0", 32'(e_m_valid), 32'h7);
    step();
    chk("rstmid_busy", 32'(e_busy), 32'd1);
    chk("rstmid_m_valid1", 32'(e_m_valid), 32'h6);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_busy_clr", 32'(e_busy), 32'd0);
    chk("rstmid_m_valid_clr", 32'(e_m_valid), 32'h7);
    e_m_ready = 3'b000;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("rstmid_resend", 32'(e_m_valid), 32'h7);
    chk("rstmid_busy_rel", 32'(e_busy), 32'd0);
    step();
    e_m_ready = 3'b111;
    @(negedge clk);
    chk("rstmid_retire", 32'(e_s_ready), 32'd1);
    step();
    e_s_valid = 0;
    step();

    // Random back-to-back traffic with random output readiness.
    rnd_en = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      while ($urandom_range(0, 3) == 0) begin
        e_s_valid = 0;
        e_s_data  = 8'($urandom);
        e_m_ready = 3'($urandom_range(0, 7));
        step();
      end
      mask = 3'($urandom_range(0, 7));
      e_s_data  = 8'(t);
      e_s_mask  = mask;
      e_s_valid = 1;
      for (int i = 0; i < 3; i++) if (mask[i]) exp_q[i].push_back(8'(t));
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 200) begin
        e_m_ready = 3'($urandom_range(0, 7));
        @(negedge clk);
        acc = e_s_ready;
        step();
        cyc++;
      end
      if (!acc) begin
        chk("token_timeout", 32'd0, 32'd1);
        break;
      end
    end
    e_s_valid = 0;
    step();
    rnd_en = 1'b0;
    chk("queues_empty", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
